// File: rtl/rob_commit_ctrl.sv
// -----------------------------------------------------------------------------
// rob_commit_ctrl
// In-order retirement sequencer for the ROB head. Waits for the head entry to
// be done, optionally gates a store on the memory-side acknowledge, retires the
// entry in a single COMMIT cycle (regfile write + ROB dequeue pulse) and, for a
// taken branch, follows with a multi-cycle flush and a one-cycle fetch redirect.
// All outputs are registered; they are computed from the next state so that
// they line up with the state they belong to.
// -----------------------------------------------------------------------------
module rob_commit_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             head_valid_i,
    input  logic             head_done_i,
    input  logic             head_is_store_i,
    input  logic             head_br_en_i,
    input  logic [31:0]      head_pc_new_i,
    input  logic             head_regf_we_i,
    input  logic [4:0]       head_rd_addr_i,
    input  logic [31:0]      head_rd_data_i,
    input  logic [4:0]       head_rob_idx_i,
    input  logic             store_ack_i,
    output logic             dequeue_o,
    output logic             regf_we_o,
    output logic [4:0]       regf_rd_addr_o,
    output logic [31:0]      regf_rd_data_o,
    output logic [4:0]       commit_rob_idx_o,
    output logic             store_req_o,
    output logic             flush_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] commit_count_o
);

    // Flush counter counts down from FLUSH_CYCLES-1 to 0 while in FLUSH.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STORE  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;

    // Head fields captured when the entry is accepted in IDLE.
    logic              lat_br_r;
    logic [31:0]       lat_pc_r;
    logic              lat_we_r;
    logic [4:0]        lat_rd_r;
    logic [31:0]       lat_data_r;
    logic [4:0]        lat_idx_r;

    // Values the latch will hold after the current edge.
    logic              lat_br_s;
    logic [31:0]       lat_pc_s;
    logic              lat_we_s;
    logic [4:0]        lat_rd_s;
    logic [31:0]       lat_data_s;
    logic [4:0]        lat_idx_s;

    logic              head_take_s;
    logic [FC_W-1:0]   flush_cnt_r;
    logic [FC_W-1:0]   flush_cnt_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_s;

    // Registered outputs and their next values.
    logic              dequeue_r;
    logic              dequeue_s;
    logic              regf_we_r;
    logic              regf_we_s;
    logic [4:0]        regf_rd_addr_r;
    logic [4:0]        regf_rd_addr_s;
    logic [31:0]       regf_rd_data_r;
    logic [31:0]       regf_rd_data_s;
    logic [4:0]        commit_idx_r;
    logic [4:0]        commit_idx_s;
    logic              store_req_r;
    logic              store_req_s;
    logic              flush_r;
    logic              flush_s;
    logic              redirect_valid_r;
    logic              redirect_valid_s;
    logic [31:0]       redirect_pc_r;
    logic [31:0]       redirect_pc_s;

    // Head is only looked at in IDLE, and only when it is both valid and done.
    always_comb begin
        head_take_s = (state_r == ST_IDLE) && head_valid_i && head_done_i;
    end

    // Next latched head fields; stores never write the regfile and x0 writes are dropped.
    always_comb begin
        lat_br_s   = lat_br_r;
        lat_pc_s   = lat_pc_r;
        lat_we_s   = lat_we_r;
        lat_rd_s   = lat_rd_r;
        lat_data_s = lat_data_r;
        lat_idx_s  = lat_idx_r;
        if (head_take_s) begin
            lat_br_s   = head_br_en_i;
            lat_pc_s   = head_pc_new_i;
            lat_we_s   = head_regf_we_i && !head_is_store_i && (head_rd_addr_i != 5'd0);
            lat_rd_s   = head_rd_addr_i;
            lat_data_s = head_rd_data_i;
            lat_idx_s  = head_rob_idx_i;
        end else begin
            lat_br_s   = lat_br_r;
        end
    end

    // Next-state logic for the retirement sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (head_take_s) begin
                    state_s = head_is_store_i ? ST_STORE : ST_COMMIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STORE: begin
                if (store_ack_i) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_STORE;
                end
            end
            ST_COMMIT: begin
                if (lat_br_r) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == {FC_W{1'b0}}) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Flush length counter and retired-instruction counter next values.
    always_comb begin
        flush_cnt_s = flush_cnt_r;
        count_s     = count_r;
        if ((state_r == ST_COMMIT) && (state_s == ST_FLUSH)) begin
            flush_cnt_s = FC_W'(FLUSH_CYCLES - 1);
        end else if ((state_r == ST_FLUSH) && (flush_cnt_r != {FC_W{1'b0}})) begin
            flush_cnt_s = flush_cnt_r - {{(FC_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_s = flush_cnt_r;
        end
        if (state_r == ST_COMMIT) begin
            count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_s = count_r;
        end
    end

    // Output values for the cycle that follows this edge (Moore on next state).
    always_comb begin
        dequeue_s        = 1'b0;
        regf_we_s        = 1'b0;
        regf_rd_addr_s   = regf_rd_addr_r;
        regf_rd_data_s   = regf_rd_data_r;
        commit_idx_s     = commit_idx_r;
        store_req_s      = 1'b0;
        flush_s          = 1'b0;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = redirect_pc_r;
        case (state_s)
            ST_STORE: begin
                store_req_s = 1'b1;
            end
            ST_COMMIT: begin
                dequeue_s      = 1'b1;
                regf_we_s      = lat_we_s;
                regf_rd_addr_s = lat_rd_s;
                regf_rd_data_s = lat_data_s;
                commit_idx_s   = lat_idx_s;
            end
            ST_FLUSH: begin
                flush_s = 1'b1;
                if (state_r == ST_COMMIT) begin
                    redirect_valid_s = 1'b1;
                    redirect_pc_s    = lat_pc_r;
                end else begin
                    redirect_valid_s = 1'b0;
                end
            end
            default: begin
                dequeue_s = 1'b0;
            end
        endcase
    end

    // State, flush counter and retire counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= {FC_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            flush_cnt_r <= flush_cnt_s;
            count_r     <= count_s;
        end
    end

    // Latched copy of the accepted head entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_br_r   <= 1'b0;
            lat_pc_r   <= 32'd0;
            lat_we_r   <= 1'b0;
            lat_rd_r   <= 5'd0;
            lat_data_r <= 32'd0;
            lat_idx_r  <= 5'd0;
        end else begin
            lat_br_r   <= lat_br_s;
            lat_pc_r   <= lat_pc_s;
            lat_we_r   <= lat_we_s;
            lat_rd_r   <= lat_rd_s;
            lat_data_r <= lat_data_s;
            lat_idx_r  <= lat_idx_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dequeue_r        <= 1'b0;
            regf_we_r        <= 1'b0;
            regf_rd_addr_r   <= 5'd0;
            regf_rd_data_r   <= 32'd0;
            commit_idx_r     <= 5'd0;
            store_req_r      <= 1'b0;
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
        end else begin
            dequeue_r        <= dequeue_s;
            regf_we_r        <= regf_we_s;
            regf_rd_addr_r   <= regf_rd_addr_s;
            regf_rd_data_r   <= regf_rd_data_s;
            commit_idx_r     <= commit_idx_s;
            store_req_r      <= store_req_s;
            flush_r          <= flush_s;
            redirect_valid_r <= redirect_valid_s;
            redirect_pc_r    <= redirect_pc_s;
        end
    end

    assign dequeue_o        = dequeue_r;
    assign regf_we_o        = regf_we_r;
    assign regf_rd_addr_o   = regf_rd_addr_r;
    assign regf_rd_data_o   = regf_rd_data_r;
    assign commit_rob_idx_o = commit_idx_r;
    assign store_req_o      = store_req_r;
    assign flush_o          = flush_r;
    assign redirect_valid_o = redirect_valid_r;
    assign redirect_pc_o    = redirect_pc_r;
    assign commit_count_o   = count_r;

endmodule
